// File: rtl/uart_pkg.sv
// uart_pkg: shared byte type and sizing constants for the UART link blocks
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_FIFO_DEPTH = 16;
  typedef logic [UART_DATA_W-1:0] byte_t;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: bridge-side write port and transmitter-side read port of the TX FIFO
// Build option UART_TX_FIFO_STATS_EN adds the max_level/byte_count statistics.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH
);
  localparam int LW = $clog2(DEPTH) + 1;
  byte_t wr_data;
  logic wr_valid;
  logic wr_ready;
  logic flush;
  byte_t tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [LW-1:0] level;
  logic overflow;
`ifdef UART_TX_FIFO_STATS_EN
  logic [LW-1:0] max_level;
  logic [31:0] byte_count;
`endif
  modport master (
    output wr_data, wr_valid, flush, tx_ready,
    input wr_ready, tx_data, tx_valid, level, overflow
`ifdef UART_TX_FIFO_STATS_EN
    , max_level, byte_count
`endif
  );
  modport slave (
    input wr_data, wr_valid, flush, tx_ready,
    output wr_ready, tx_data, tx_valid, level, overflow
`ifdef UART_TX_FIFO_STATS_EN
    , max_level, byte_count
`endif
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through byte FIFO feeding the UART transmitter
// Build option UART_TX_FIFO_STATS_EN adds high-water mark and popped-byte counter.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH
) (
  input logic clk,
  input logic rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  byte_t mem [DEPTH];
  logic full, empty, push, pop, ovf;
  // pointers carry an extra wrap bit so full and empty are distinguishable
  always_comb begin
    empty = wr_ptr == rd_ptr;
    full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    push = bus.wr_valid && !full;
    pop = bus.tx_ready && !empty;
  end
  assign bus.wr_ready = !full;
  assign bus.tx_valid = !empty;
  assign bus.tx_data = mem[rd_ptr[AW-1:0]];
  assign bus.level = wr_ptr - rd_ptr;
  assign bus.overflow = ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf <= 1'b0;
      mem <= '{default: '0};
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) mem[wr_ptr[AW-1:0]] <= bus.wr_data;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (bus.wr_valid && full) ovf <= 1'b1;
    end
  end
`ifdef UART_TX_FIFO_STATS_EN
  logic [PW-1:0] max_lvl;
  logic [31:0] cnt;
  assign bus.max_level = max_lvl;
  assign bus.byte_count = cnt;
  // byte_count survives flush: it tracks bytes actually handed to the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_lvl <= '0;
      cnt <= '0;
    end else begin
      max_lvl <= bus.flush ? '0 : (bus.level > max_lvl ? bus.level : max_lvl);
      if (pop && !bus.flush) cnt <= cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed stimulus with a byte scoreboard checked by a separate monitor
module tb_uart_tx_fifo;
  import uart_pkg::*;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  int mdl_level = 0;
  bit mdl_ovf = 1'b0;
  byte_t exp_q[$];
  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();
  uart_tx_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic chk_state(input string tag);
    check({tag, " level"}, 32'(bus.level), 32'(mdl_level));
    check({tag, " tx_valid"}, 32'(bus.tx_valid), 32'(mdl_level != 0));
    check({tag, " wr_ready"}, 32'(bus.wr_ready), 32'(mdl_level != DEPTH));
    check({tag, " overflow"}, 32'(bus.overflow), 32'(mdl_ovf));
  endtask
  task automatic cyc(input logic wv, input byte_t d, input logic tr, input logic fl = 1'b0);
    bus.wr_valid = wv;
    bus.wr_data = d;
    bus.tx_ready = tr;
    bus.flush = fl;
    if (fl) begin
      exp_q.delete();
      mdl_level = 0;
      mdl_ovf = 1'b0;
    end else begin
      int nl;
      nl = mdl_level;
      if (wv && mdl_level == DEPTH) mdl_ovf = 1'b1;
      if (wv && mdl_level < DEPTH) begin
        exp_q.push_back(d);
        nl++;
      end
      if (tr && mdl_level > 0) nl--;
      mdl_level = nl;
    end
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    bus.tx_ready = 1'b0;
    bus.flush = 1'b0;
  endtask
  // monitor: a pop happens at the next edge whenever valid && ready with no flush
  always @(negedge clk) begin
    if (rst_n && bus.tx_valid && bus.tx_ready && !bus.flush) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected no byte at %0t", bus.tx_data, $time);
      end else begin
        check("pop_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int sent, i;
    bit up;
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.tx_ready = 1'b0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("in_reset tx_valid", 32'(bus.tx_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_state("reset");
    check("reset tx_data", 32'(bus.tx_data), 32'h0);
    cyc(1'b1, 8'hA5, 1'b0);
    chk_state("single push");
    check("single tx_data", 32'(bus.tx_data), 32'hA5);
    cyc(1'b0, 8'h00, 1'b1);
    chk_state("single pop");
    for (int k = 0; k < DEPTH; k++) cyc(1'b1, 8'(k), 1'b0);
    chk_state("filled");
    cyc(1'b1, 8'hFF, 1'b0);
    chk_state("overflow push");
    check("full head", 32'(bus.tx_data), 32'h00);
    while (mdl_level > 0) cyc(1'b0, 8'h00, 1'b1);
    chk_state("drained");
    check("queue empty after fill", 32'(exp_q.size()), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk_state("flush clears overflow");
    sent = 0;
    i = 0;
    up = 1'b1;
    while (sent < 40) begin
      logic wv, tr;
      if (mdl_level >= 12) up = 1'b0;
      else if (mdl_level <= 3) up = 1'b1;
      wv = up ? 1'b1 : (i % 3 == 0);
      tr = up ? (i % 3 == 0) : 1'b1;
      cyc(wv, 8'(8'h40 + sent), tr);
      chk_state("wrap");
      if (wv) sent++;
      i++;
    end
    while (mdl_level > 0) cyc(1'b0, 8'h00, 1'b1);
    check("queue empty after wrap", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'h50 + k), 1'b0);
    cyc(1'b1, 8'h55, 1'b1);
    chk_state("push_pop level5");
    while (mdl_level < DEPTH) cyc(1'b1, 8'(8'h60 + mdl_level), 1'b0);
    chk_state("full again");
    cyc(1'b1, 8'h77, 1'b1);
    chk_state("full pop only");
    while (mdl_level > 0) cyc(1'b0, 8'h00, 1'b1);
    check("queue empty after full pop", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < 7; k++) cyc(1'b1, 8'(8'h80 + k), 1'b0);
    chk_state("level7");
    cyc(1'b1, 8'h99, 1'b0, 1'b1);
    chk_state("after flush");
    cyc(1'b1, 8'h3C, 1'b0);
    check("post flush head", 32'(bus.tx_data), 32'h3C);
    cyc(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'hC0 + k), 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    bus.tx_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    mdl_level = 0;
    mdl_ovf = 1'b0;
    #1;
    bus.tx_ready = 1'b0;
    chk_state("async reset");
    check("async reset tx_data", 32'(bus.tx_data), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_state("after reset release");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
